sha256_round_controller: RTL and testbench
==========================================

Name: sha256_round_controller

Overview:
- Sequences one SHA-256 compression engine (the 64-round hash datapath) across one or more 512-bit message blocks.
- Holds the chaining hash H and loads the IV on the first block.
- Drives engine enable, round index, round constant and final-add strobe, then captures the engine result into H and presents the digest.
- Sits between the top-level block feeder / message scheduler and the round engine.

Parameters:
- WK_LENGTH, 64, rounds per block; round_index width is $clog2(WK_LENGTH).
- CAPTURE_TIMEOUT, 4, maximum cycles in CAPTURE waiting for engine_done before raising error.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a block; accepted only when ready=1.
- first_block  in  1  sampled with start; 1 loads IV into H.
- abort  in  1  return to IDLE; H unchanged.
- ready  out  1  high in IDLE only.
- round_enable  out  1  engine enable.
- round_last  out  1  engine final-add strobe (wk_index_complete).
- round_index  out  $clog2(WK_LENGTH)  current round; also the W index to the message scheduler.
- cur_k  out  32  K[round_index].
- prev_hash  out  256  H in engine order: word a at [31:0] … word h at [255:224].
- engine_done  in  1  engine hash_complete.
- engine_hash  in  256  engine updated_hash, digest order: a at [255:224].
- digest_valid  out  1  one-cycle pulse when H is updated.
- digest  out  256  H register, digest order (H0 at [255:224]).
- error  out  1  one-cycle pulse on capture timeout.

Behaviour:
- Reset (async, reset=0): state=IDLE, H=0, round_index=0, and round_enable, round_last, digest_valid and error all 0. ready=1 once reset is released.
- prev_hash = word-reversal of H (combinational). digest = H.
- IDLE:
  - start & ready & !abort → LOAD at the next edge.
  - If first_block=1, H←IV at the same edge.
- LOAD (1 cycle): round_enable=0, so the engine loads prev_hash. round_index=0. → ROUND.
- ROUND:
  - round_enable=1, round_last=0.
  - round_index counts 0..WK_LENGTH-1, one per cycle.
  - At WK_LENGTH-1 → FINAL.
  - The scheduler must supply W[round_index] combinationally in the same cycle; there is no stall.
- FINAL (1 cycle): round_enable=1, round_last=1, cur_k=0. → CAPTURE.
- CAPTURE:
  - round_enable=1, round_last=1.
  - When engine_done=1: H←engine_hash, digest_valid pulses the next cycle → IDLE.
  - A conforming engine asserts engine_done in the first CAPTURE cycle.
  - If CAPTURE_TIMEOUT cycles pass without engine_done: error pulse, H unchanged → IDLE.
- Latency: start accepted at edge T → digest_valid high in cycle T+WK_LENGTH+4 (68 for default).
- abort:
  - In any non-IDLE state → IDLE at the next edge; H unchanged; no digest_valid.
  - abort has priority over start, and over engine_done in CAPTURE.
- start while not ready: ignored; not queued.
- Reset mid-operation: immediate return to reset values; any partial block is discarded.
- Arithmetic: round counter wraps only via the state transition and never increments past WK_LENGTH-1. All additions are inside the engine; the controller does no arithmetic on H.

Optional Feature:
- Macro SHA224_MODE_EN.
- Defined:
  - Adds input mode_224 (1 bit), sampled with start.
  - When mode_224=1 and first_block=1, H←SHA-224 IV.
  - digest[31:0] forced to 0 whenever the last accepted block was mode_224; H itself stays full.
- Undefined: no mode_224 port; SHA-256 IV only.

Decomposition:
- Package sha256_pkg:
  - 64-entry K table.
  - SHA256_IV and SHA224_IV constants (256-bit, digest order).
  - State enum {IDLE, LOAD, ROUND, FINAL, CAPTURE}.
  - Word-reverse function.
- One sub-module: sha256_k_rom, a combinational lookup from round_index to cur_k.

Test Plan:
- Reset/idle: assert reset mid-ROUND (round_index=30) → all outputs zero immediately; after release ready=1, digest=0.
- Single block "abc" (padded), first_block=1, with engine and scheduler models:
  - round_index runs 0..63 in 64 consecutive cycles.
  - digest_valid at start+68.
  - digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two blocks "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Second block uses first_block=0, and prev_hash equals the word-reversed block-1 digest.
  - Final digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Abort at round_index=20 → ready=1 next cycle; no digest_valid; digest unchanged from the prior value. A start in the same cycle as abort in IDLE is ignored.
- engine_done tied low → error pulses exactly once, 4 cycles after entering CAPTURE; H unchanged; ready=1.
- With SHA224_MODE_EN, "abc" in mode_224 → digest=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-256 round controller: round constants, initial hash values,
// controller states and the word-order helper.
package sha256_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, CAPTURE} state_t;

  // Initial hash values in digest order (H0 in the top word).
  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] SHA224_IV = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Digest order (a in the top word) <-> engine order (a in the bottom word).
  function automatic logic [255:0] word_reverse(input logic [255:0] h);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = h[32*(7-i) +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup indexed by the current round.
import sha256_pkg::*;

module sha256_k_rom #(
  parameter int IDX_W = 6
) (
  input  logic [IDX_W-1:0] round_index,
  output logic [31:0]      k
);

  always_comb k = K_TABLE[6'(round_index)];

endmodule

// File: rtl/sha256_round_controller.sv
// Sequences one SHA-256 round engine over message blocks and owns the chaining hash H.
// Build option SHA224_MODE_EN adds a mode_224 input selecting the SHA-224 IV and truncation.
import sha256_pkg::*;

module sha256_round_controller #(
  parameter  int WK_LENGTH       = 64,
  parameter  int CAPTURE_TIMEOUT = 4,
  localparam int IDX_W           = $clog2(WK_LENGTH),
  localparam int TO_W            = $clog2(CAPTURE_TIMEOUT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             first_block,
  input  logic             abort,
`ifdef SHA224_MODE_EN
  input  logic             mode_224,
`endif
  output logic             ready,
  output logic             round_enable,
  output logic             round_last,
  output logic [IDX_W-1:0] round_index,
  output logic [31:0]      cur_k,
  output logic [255:0]     prev_hash,
  input  logic             engine_done,
  input  logic [255:0]     engine_hash,
  output logic             digest_valid,
  output logic [255:0]     digest,
  output logic             error
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WK_LENGTH - 1);
  localparam logic [TO_W-1:0]  LAST_WAIT = TO_W'(CAPTURE_TIMEOUT - 1);

  state_t          state, state_next;
  logic [255:0]    hash_q;
  logic [255:0]    iv_sel;
  logic [TO_W-1:0] wait_cnt;
  logic [31:0]     k_rom;
  logic            accept, capture_hit, capture_timeout;

  // Handshake: a block is taken on the edge where start=1 and ready=1 and abort=0;
  // start at any other time is dropped, never queued.
  assign ready           = (state == IDLE) && reset;
  assign accept          = (state == IDLE) && start && !abort;
  assign capture_hit     = (state == CAPTURE) && !abort && engine_done;
  assign capture_timeout = (state == CAPTURE) && !abort && !engine_done && (wait_cnt == LAST_WAIT);

`ifdef SHA224_MODE_EN
  logic mode_q;
  assign iv_sel = mode_224 ? SHA224_IV : SHA256_IV;
  assign digest = {hash_q[255:32], mode_q ? 32'h0 : hash_q[31:0]};
`else
  assign iv_sel = SHA256_IV;
  assign digest = hash_q;
`endif

  assign prev_hash = word_reverse(hash_q);
  assign cur_k     = (state == ROUND) ? k_rom : 32'h0;

  sha256_k_rom #(.IDX_W(IDX_W)) u_k_rom (
    .round_index (round_index),
    .k           (k_rom)
  );

  always_comb begin
    state_next = state;
    if (abort && state != IDLE) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = LOAD;
        LOAD:    state_next = ROUND;
        ROUND:   if (round_index == LAST_IDX) state_next = FINAL;
        FINAL:   state_next = CAPTURE;
        CAPTURE: if (capture_hit || capture_timeout) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    round_enable = 1'b0;
    round_last   = 1'b0;
    case (state)
      ROUND: round_enable = 1'b1;
      FINAL, CAPTURE: begin
        round_enable = 1'b1;
        round_last   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      hash_q       <= '0;
      round_index  <= '0;
      wait_cnt     <= '0;
      digest_valid <= 1'b0;
      error        <= 1'b0;
`ifdef SHA224_MODE_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      digest_valid <= capture_hit;
      error        <= capture_timeout;
      // The counter only advances while staying in ROUND, so it can never pass LAST_IDX.
      if (state == ROUND && state_next == ROUND) round_index <= round_index + IDX_W'(1);
      else                                       round_index <= '0;
      if (state == CAPTURE) wait_cnt <= wait_cnt + TO_W'(1);
      else                  wait_cnt <= '0;
      if (accept && first_block) hash_q <= iv_sel;
      else if (capture_hit)      hash_q <= engine_hash;
`ifdef SHA224_MODE_EN
      if (accept) mode_q <= mode_224;
`endif
    end
  end

endmodule

// File: tb/tb_sha256_round_controller.sv
// Directed bench for sha256_round_controller with a behavioural round engine and message scheduler.
// The SHA-224 step runs only when SHA224_MODE_EN is defined.
module tb_sha256_round_controller;

  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_H1  = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [255:0] D_H2  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] M_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] M_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M_B2  = {480'h0, 32'h000001c0};

  logic         clock = 1'b0;
  logic         reset, start, first_block, abort;
  logic         ready, round_enable, round_last, digest_valid, error;
  logic [5:0]   round_index;
  logic [31:0]  cur_k;
  logic [255:0] prev_hash, digest;
  logic         engine_done;
  logic [255:0] engine_hash = '0;
  logic         engine_done_r = 1'b0;
  logic         engine_stall = 1'b0;
`ifdef SHA224_MODE_EN
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] D_224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  logic         mode_224 = 1'b0;
`endif

  int n_compared = 0;
  int n_mismatched = 0;

  sha256_round_controller dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .first_block  (first_block),
    .abort        (abort),
`ifdef SHA224_MODE_EN
    .mode_224     (mode_224),
`endif
    .ready        (ready),
    .round_enable (round_enable),
    .round_last   (round_last),
    .round_index  (round_index),
    .cur_k        (cur_k),
    .prev_hash    (prev_hash),
    .engine_done  (engine_done),
    .engine_hash  (engine_hash),
    .digest_valid (digest_valid),
    .digest       (digest),
    .error        (error)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scheduler and engine models ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] rev_words(input logic [255:0] h);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = h[255-32*i -: 32];
    return r;
  endfunction

  logic [31:0] w_mem [64];
  logic [31:0] sched_w;
  assign sched_w = w_mem[round_index];

  task automatic load_msg(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w_mem[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w_mem[i-15], 7) ^ rotr(w_mem[i-15], 18) ^ (w_mem[i-15] >> 3);
      s1 = rotr(w_mem[i-2], 17) ^ rotr(w_mem[i-2], 19) ^ (w_mem[i-2] >> 10);
      w_mem[i] = w_mem[i-16] + s0 + w_mem[i-7] + s1;
    end
  endtask

  logic [31:0]  va, vb, vc, vd, ve, vf, vg, vh;
  logic [255:0] hin;
  logic         fin_seen = 1'b0;
  assign engine_done = engine_done_r && !engine_stall;

  always @(posedge clock) begin
    logic [31:0] t1, t2;
    if (!round_enable) begin
      hin <= prev_hash;
      va <= prev_hash[31:0];    vb <= prev_hash[63:32];
      vc <= prev_hash[95:64];   vd <= prev_hash[127:96];
      ve <= prev_hash[159:128]; vf <= prev_hash[191:160];
      vg <= prev_hash[223:192]; vh <= prev_hash[255:224];
      fin_seen <= 1'b0;
      engine_done_r <= 1'b0;
    end else if (!round_last) begin
      t1 = vh + (rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + cur_k + sched_w;
      t2 = (rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
      vh <= vg; vg <= vf; vf <= ve; ve <= vd + t1;
      vd <= vc; vc <= vb; vb <= va; va <= t1 + t2;
    end else if (!fin_seen) begin
      fin_seen <= 1'b1;
      engine_hash <= {hin[31:0] + va, hin[63:32] + vb, hin[95:64] + vc, hin[127:96] + vd,
                      hin[159:128] + ve, hin[191:160] + vf, hin[223:192] + vg, hin[255:224] + vh};
      engine_done_r <= 1'b1;
    end else begin
      engine_done_r <= 1'b0;
    end
  end

  // ---------------- checking and driver tasks ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_block(input logic fb);
    @(negedge clock);
    start = 1'b1;
    first_block = fb;
    @(negedge clock);
    start = 1'b0;
    first_block = 1'b0;
  endtask

  task automatic wait_index(input string tag, input int idx);
    bit found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clock);
      if (round_enable && !round_last && round_index == 6'(idx)) found = 1;
    end
    check(tag, found, 1'b1);
  endtask

  // Full block: start in cycle 0, LOAD in 1, rounds in 2..65, FINAL 66, CAPTURE 67, digest_valid 68.
  task automatic run_block(input string tag, input logic fb, input logic [255:0] exp_prev);
    int lat = 0;
    bit seq_ok = 1;
    start_block(fb);
    check({tag, "_load"}, {ready, round_enable, round_index}, 8'h00);
    check({tag, "_prev_hash"}, prev_hash, exp_prev);
    for (int c = 2; c <= 100 && lat == 0; c++) begin
      @(negedge clock);
      if (c <= 65 && !(round_enable && !round_last && round_index == 6'(c - 2) && cur_k != 32'h0)) seq_ok = 0;
      if (c == 66) check({tag, "_final"}, {round_enable, round_last, cur_k}, {2'b11, 32'h0});
      if (digest_valid) lat = c;
    end
    check({tag, "_round_seq"}, seq_ok, 1'b1);
    check({tag, "_latency"}, lat, 68);
    @(negedge clock);
    check({tag, "_pulse_end"}, {digest_valid, ready}, 2'b01);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit         seen_dv;
    logic [5:0] err_v;
    reset = 1'b0;
    start = 1'b0;
    first_block = 1'b0;
    abort = 1'b0;
    load_msg(M_ABC);
    repeat (3) @(negedge clock);
    check("in_reset", {ready, round_enable, round_last, digest_valid, error}, 5'b0);
    reset = 1'b1;
    #1;
    check("post_reset_ready", ready, 1'b1);
    check("post_reset_outs", {round_enable, round_last, round_index, cur_k, digest_valid, error}, '0);
    check("post_reset_hash", {digest, prev_hash}, '0);

    // Reset in the middle of a block.
    start_block(1'b1);
    wait_index("mid_wait30", 30);
    reset = 1'b0;
    #1;
    check("mid_reset_ctrl", {ready, round_enable, round_last, round_index, cur_k, digest_valid, error}, '0);
    check("mid_reset_hash", {digest, prev_hash}, '0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_release", {ready, digest}, {1'b1, 256'h0});

    // Single block "abc".
    run_block("abc", 1'b1, rev_words(IV256));
    check("abc_digest", digest, D_ABC);

    // Two-block message, chaining through H.
    load_msg(M_B1);
    run_block("blk1", 1'b1, rev_words(IV256));
    check("blk1_digest", digest, D_H1);
    load_msg(M_B2);
    run_block("blk2", 1'b0, rev_words(D_H1));
    check("blk2_digest", digest, D_H2);

    // Abort mid-round.
    load_msg(M_ABC);
    start_block(1'b0);
    wait_index("abort_wait20", 20);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_ready", {ready, round_enable}, 2'b10);
    seen_dv = 0;
    repeat (80) begin
      @(negedge clock);
      if (digest_valid) seen_dv = 1;
    end
    check("abort_no_dv", seen_dv, 1'b0);
    check("abort_digest", digest, D_H2);

    // start together with abort in IDLE is dropped.
    @(negedge clock);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_start", {ready, round_enable}, 2'b10);

    // Engine never reports done: one error pulse, H kept.
    engine_stall = 1'b1;
    start_block(1'b0);
    seen_dv = 0;
    for (int c = 0; c < 100 && !seen_dv; c++) begin
      @(negedge clock);
      if (round_last) seen_dv = 1;
    end
    check("to_reach_final", seen_dv, 1'b1);
    seen_dv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      err_v[k] = error;
      if (digest_valid) seen_dv = 1;
      if (k == 4) check("to_ready", ready, 1'b1);
    end
    check("to_error_seq", err_v, 6'b010000);
    check("to_no_dv", seen_dv, 1'b0);
    check("to_digest", digest, D_H2);
    engine_stall = 1'b0;

`ifdef SHA224_MODE_EN
    mode_224 = 1'b1;
    run_block("sha224", 1'b1, rev_words(IV224));
    check("sha224_digest", digest, D_224);
    mode_224 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
